// File: rtl/xilly_fifo_pkg.sv
// Shared constants for the Xillybus 128-bit write-side FIFO.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Holds the data width, the default depth and the default almost-full level,
// so the FIFO top and any wrapper agree on them.
package xilly_fifo_pkg;

  // Width of one Xillybus write word.
  localparam int DATA_W = 128;

  // Default number of entries and the matching almost-full threshold.
  localparam int DEPTH_DEF = 16;
  localparam int AFULL_DEF = DEPTH_DEF - 2;

  typedef logic [DATA_W-1:0] word_t;

  // Almost-full default for an arbitrary depth: two entries of headroom,
  // enough for the core to see the flag before the last slot is gone.
  function automatic int afull_lvl_for(input int depth);
    return depth - 2;
  endfunction

endpackage

// File: rtl/xilly_dpram.sv
// Simple dual-port RAM: one synchronous write port, one asynchronous read port.
// Latency: write visible on rdata_o the cycle after the write edge; read is combinational.
// Backpressure: none; the caller decides when writes are legal.
//
// Ports:
//   clk_i    - write clock
//   we_i     - write enable
//   waddr_i  - write address
//   wdata_i  - write data
//   raddr_i  - read address
//   rdata_o  - read data, mem[raddr_i]
//
// Contents are deliberately not reset, so this maps onto distributed RAM.
module xilly_dpram #(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int DW    = 128
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/xilly_write_fifo_128.sv
// First-word-fall-through FIFO from the Xillybus 128-bit write stream to an HLS ap_fifo consumer.
// Latency: a written word is on ap_dout with ap_empty_n=1 one cycle after its write edge.
// Backpressure: user_w_write_128_full holds off the core at DEPTH entries; writes while full are dropped (ovf_err).
//
// Ports:
//   bus_clk                - single clock, shared with xillybus_core
//   trn_reset_n            - asynchronous active-low reset
//   user_w_write_128_wren  - write strobe from core
//   user_w_write_128_data  - write word from core
//   user_w_write_128_open  - host file open, status only
//   user_w_write_128_full  - occupancy == DEPTH
//   ap_read                - consumer read strobe
//   ap_dout                - head-of-queue word (don't-care when empty)
//   ap_empty_n             - head word valid
//   almost_full            - occupancy >= AFULL_LVL
//   occupancy              - current entry count
//   ovf_err                - sticky: a write was dropped
//   udf_err                - sticky: a read was ignored
module xilly_write_fifo_128
  import xilly_fifo_pkg::*;
#(
  parameter int DEPTH     = DEPTH_DEF,
  parameter int AFULL_LVL = afull_lvl_for(DEPTH)
) (
  input  logic                     bus_clk,
  input  logic                     trn_reset_n,
  input  logic                     user_w_write_128_wren,
  input  logic [DATA_W-1:0]        user_w_write_128_data,
  input  logic                     user_w_write_128_open,
  output logic                     user_w_write_128_full,
  input  logic                     ap_read,
  output logic [DATA_W-1:0]        ap_dout,
  output logic                     ap_empty_n,
  output logic                     almost_full,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic                     ovf_err,
  output logic                     udf_err
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0]   AFULL_C = (AW+1)'(AFULL_LVL);
  localparam logic [AW-1:0] PTR_ONE = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [AW:0]   CNT_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic          udf_q, udf_d;

  logic          is_full;
  logic          is_nonempty;
  logic          wr_ok;
  logic          rd_ok;

  // The open flag is status only; the queue keeps its contents across a
  // close/reopen, so it never enters the datapath.
  logic          unused_open;
  assign unused_open = user_w_write_128_open;

  // Status decoded from the registered count only, so neither strobe has a
  // combinational path to full/almost_full/empty.
  assign is_full     = (cnt_q == DEPTH_C);
  assign is_nonempty = (cnt_q != '0);

  // Acceptance uses the pre-edge count: at full a simultaneous read frees a
  // slot only after the edge, so the write is still dropped; at empty the
  // read has nothing to take even though a write lands on the same edge.
  assign wr_ok = user_w_write_128_wren & ~is_full;
  assign rd_ok = ap_read & is_nonempty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q | (user_w_write_128_wren & is_full);
    udf_d    = udf_q | (ap_read & ~is_nonempty);

    if (wr_ok) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (rd_ok) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end

    unique case ({wr_ok, rd_ok})
      2'b10:   cnt_d = cnt_q + CNT_ONE;
      2'b01:   cnt_d = cnt_q - CNT_ONE;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge bus_clk or negedge trn_reset_n) begin
    if (!trn_reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  // Storage is not reset; resetting the pointers is enough to discard
  // whatever was queued.
  xilly_dpram #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (DATA_W)
  ) u_ram (
    .clk_i   (bus_clk),
    .we_i    (wr_ok),
    .waddr_i (wr_ptr_q),
    .wdata_i (user_w_write_128_data),
    .raddr_i (rd_ptr_q),
    .rdata_o (ap_dout)
  );

  assign user_w_write_128_full = is_full;
  assign almost_full           = (cnt_q >= AFULL_C);
  assign ap_empty_n            = is_nonempty;
  assign occupancy             = cnt_q;
  assign ovf_err               = ovf_q;
  assign udf_err               = udf_q;

endmodule

// File: tb/tb_xilly_write_fifo_128.sv
// Directed bench for xilly_write_fifo_128 at the default DEPTH=16, AFULL_LVL=14.
// Inputs change 1 time unit after a rising edge; outputs are checked there too.
module tb_xilly_write_fifo_128;

  logic         bus_clk;
  logic         trn_reset_n;
  logic         wren;
  logic [127:0] wdata;
  logic         wopen;
  logic         wfull;
  logic         ap_read;
  logic [127:0] ap_dout;
  logic         ap_empty_n;
  logic         almost_full;
  logic [4:0]   occupancy;
  logic         ovf_err;
  logic         udf_err;

  int n_chk  = 0;
  int n_fail = 0;

  xilly_write_fifo_128 dut (
    .bus_clk               (bus_clk),
    .trn_reset_n           (trn_reset_n),
    .user_w_write_128_wren (wren),
    .user_w_write_128_data (wdata),
    .user_w_write_128_open (wopen),
    .user_w_write_128_full (wfull),
    .ap_read               (ap_read),
    .ap_dout               (ap_dout),
    .ap_empty_n            (ap_empty_n),
    .almost_full           (almost_full),
    .occupancy             (occupancy),
    .ovf_err               (ovf_err),
    .udf_err               (udf_err)
  );

  initial bus_clk = 1'b0;
  always #5 bus_clk = ~bus_clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge bus_clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_occ"},   occupancy,   0);
    chk({tag, "_full"},  wfull,       0);
    chk({tag, "_afull"}, almost_full, 0);
    chk({tag, "_vld"},   ap_empty_n,  0);
    chk({tag, "_ovf"},   ovf_err,     0);
    chk({tag, "_udf"},   udf_err,     0);
  endtask

  initial begin
    trn_reset_n = 1'b0;
    wren        = 1'b0;
    wdata       = '0;
    wopen       = 1'b1;
    ap_read     = 1'b0;

    // Reset state, before any clock edge.
    #3;
    chk_reset_outputs("rst");
    step();
    step();
    trn_reset_n = 1'b1;
    step();

    // Five writes, no reads.
    for (int i = 1; i <= 5; i++) begin
      wren  = 1'b1;
      wdata = 128'(i);
      step();
      chk("w5_occ", occupancy, 128'(i));
    end
    wren = 1'b0;
    chk("w5_vld", ap_empty_n, 1);
    chk("w5_head", ap_dout, 128'h1);

    // Closing and reopening the file leaves the queue alone.
    wopen = 1'b0;
    step();
    wopen = 1'b1;
    step();
    chk("reopen_occ", occupancy, 5);
    chk("reopen_head", ap_dout, 128'h1);

    // Read back 1..5.
    for (int i = 1; i <= 5; i++) begin
      chk("r5_dout", ap_dout, 128'(i));
      ap_read = 1'b1;
      step();
      chk("r5_occ", occupancy, 128'(5 - i));
    end
    ap_read = 1'b0;
    chk("r5_vld", ap_empty_n, 0);

    // Fill to 16, watching full and almost_full thresholds.
    for (int i = 1; i <= 16; i++) begin
      wren  = 1'b1;
      wdata = 128'(32'h100 + i);
      step();
      chk("fill_full", wfull, (i == 16) ? 128'd1 : 128'd0);
      chk("fill_afull", almost_full, (i >= 14) ? 128'd1 : 128'd0);
    end
    chk("fill_occ", occupancy, 16);

    // Write while full: dropped.
    wdata = 128'hDEAD;
    step();
    wren = 1'b0;
    chk("ovf_flag", ovf_err, 1);
    chk("ovf_occ", occupancy, 16);
    chk("ovf_full", wfull, 1);
    chk("ovf_head", ap_dout, 128'h101);

    // Write and read together while full: read wins, write dropped.
    wren    = 1'b1;
    wdata   = 128'hBEEF;
    ap_read = 1'b1;
    step();
    wren    = 1'b0;
    ap_read = 1'b0;
    chk("fr_occ", occupancy, 15);
    chk("fr_ovf", ovf_err, 1);
    chk("fr_full", wfull, 0);
    chk("fr_head", ap_dout, 128'h102);

    // Drain; neither 0xDEAD nor 0xBEEF may appear.
    for (int i = 2; i <= 16; i++) begin
      chk("drain_dout", ap_dout, 128'(32'h100 + i));
      ap_read = 1'b1;
      step();
    end
    ap_read = 1'b0;
    chk("drain_occ", occupancy, 0);
    chk("drain_udf", udf_err, 0);

    // Write and read together while empty: write lands, read ignored.
    wren    = 1'b1;
    wdata   = 128'hAA;
    ap_read = 1'b1;
    step();
    wren    = 1'b0;
    ap_read = 1'b0;
    chk("er_udf", udf_err, 1);
    chk("er_occ", occupancy, 1);
    chk("er_vld", ap_empty_n, 1);
    chk("er_head", ap_dout, 128'hAA);
    ap_read = 1'b1;
    step();
    ap_read = 1'b0;
    chk("er_drain_occ", occupancy, 0);

    // Stream 40 words: 14 write-only, 26 write+read, then drain 14.
    begin
      int r;
      r = 0;
      for (int k = 0; k < 14; k++) begin
        wren  = 1'b1;
        wdata = 128'(32'h1000 + k);
        step();
        chk("st_afull", almost_full, (k + 1 >= 14) ? 128'd1 : 128'd0);
      end
      chk("st_occ14", occupancy, 14);
      for (int k = 14; k < 40; k++) begin
        chk("st_dout", ap_dout, 128'(32'h1000 + r));
        wren    = 1'b1;
        wdata   = 128'(32'h1000 + k);
        ap_read = 1'b1;
        step();
        r++;
      end
      wren = 1'b0;
      chk("st_occ_mid", occupancy, 14);
      chk("st_afull_mid", almost_full, 1);
      for (int k = 0; k < 14; k++) begin
        chk("st_drain", ap_dout, 128'(32'h1000 + r));
        ap_read = 1'b1;
        step();
        r++;
        chk("st_afull_drop", almost_full, 0);
      end
      ap_read = 1'b0;
      chk("st_occ_end", occupancy, 0);
    end

    // Reset mid-transfer, between edges.
    for (int i = 0; i < 7; i++) begin
      wren  = 1'b1;
      wdata = 128'(32'h2000 + i);
      step();
    end
    wren = 1'b0;
    chk("pre_rst_occ", occupancy, 7);
    trn_reset_n = 1'b0;
    #2;
    chk_reset_outputs("mid_rst");
    #1;
    trn_reset_n = 1'b1;
    step();
    wren  = 1'b1;
    wdata = 128'h5555;
    step();
    wren = 1'b0;
    chk("post_rst_head", ap_dout, 128'h5555);
    chk("post_rst_occ", occupancy, 1);
    chk("post_rst_vld", ap_empty_n, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
